// File: rtl/tdc_ctrl_pkg.sv
// Shared definitions for the TDC measurement controller.
//   state_t       : controller state encoding
//   DEF_*         : default geometry (counter width, hit slots, window, start width)
//   SYNC_LAT      : trig synchroniser depth in clk cycles
//   hit_cnt_w()   : width needed to hold a hit count of 0..max_hits
package tdc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WIN    = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MAX_HITS = 3;
  localparam int unsigned DEF_WINDOW   = 512;
  localparam int unsigned DEF_START_W  = 4;
  localparam int unsigned SYNC_LAT     = 2;

  // Counter width able to represent 0..max_hits inclusive.
  function automatic int unsigned hit_cnt_w(input int unsigned max_hits);
    return $clog2(max_hits + 1);
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level input followed by a
// rising-edge detector on the synchronised level.
//   clk, rst   : clock, synchronous active-high reset
//   async_in   : asynchronous input (must stay high >= 2 clk cycles)
//   rise_c     : combinational one-cycle pulse on a synchronised rising edge
module trig_sync_edge
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  // sync_q[0] is the metastability flop, sync_q[STAGES-1] the settled level.
  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequencer for one TDC ranging measurement: issues the start pulse, opens a
// fixed coarse-time window, timestamps up to MAX_HITS synchronised trig edges
// and offers the result record over a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   meas_req   : single-cycle measurement request (honoured in IDLE only)
//   trig       : asynchronous APD return pulse
//   tdc_start  : start pulse, high for START_W cycles
//   busy       : high whenever not IDLE
//   req_drop   : one-cycle pulse for a request arriving outside IDLE
//   res_valid  : result record valid (REPORT)
//   res_ready  : downstream accepts the record
//   hit_cnt    : number of stored timestamps
//   hit_ts     : timestamps, slot i at [i*CNT_W +: CNT_W]
//   hit_ovf    : at least one edge discarded because all slots were full
// WINDOW must satisfy 8 <= WINDOW < 2**CNT_W.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_HITS = DEF_MAX_HITS,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned START_W  = DEF_START_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              meas_req,
  input  logic                              trig,
  output logic                              tdc_start,
  output logic                              busy,
  output logic                              req_drop,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [hit_cnt_w(MAX_HITS)-1:0]    hit_cnt,
  output logic [MAX_HITS*CNT_W-1:0]         hit_ts,
  output logic                              hit_ovf
);

  localparam int unsigned HC_W = hit_cnt_w(MAX_HITS);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             trig_rise_c;

  // Per-cycle control strobes decoded alongside the next state.
  logic             start_go;
  logic             cnt_run;
  logic             hit_wr;
  logic             ovf_set;
  logic             drop;

  trig_sync_edge #(
    .STAGES (SYNC_LAT)
  ) u_trig_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (trig),
    .rise_c   (trig_rise_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nx = state;
    start_go = 1'b0;
    cnt_run  = 1'b0;
    hit_wr   = 1'b0;
    ovf_set  = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (meas_req) begin
          state_nx = ST_START;
          start_go = 1'b1;
        end
      end
      ST_START: begin
        cnt_run = 1'b1;
        drop    = meas_req;
        if (cnt == CNT_W'(START_W - 1)) begin
          state_nx = ST_WIN;
        end
      end
      ST_WIN: begin
        cnt_run = 1'b1;
        drop    = meas_req;
        if (cnt == CNT_W'(WINDOW - 1)) begin
          state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        drop = meas_req;
        if (res_valid && res_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Edges only count while the counter runs; the final WIN cycle included.
    if (cnt_run && trig_rise_c) begin
      if (hit_cnt < HC_W'(MAX_HITS)) begin
        hit_wr = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // Status outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdc_start <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      req_drop  <= 1'b0;
    end else begin
      tdc_start <= (state_nx == ST_START);
      busy      <= (state_nx != ST_IDLE);
      res_valid <= (state_nx == ST_REPORT);
      req_drop  <= drop;
    end
  end

  // Coarse counter and result record; record is only cleared on START entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hit_cnt <= '0;
      hit_ts  <= '0;
      hit_ovf <= 1'b0;
    end else if (start_go) begin
      cnt     <= '0;
      hit_cnt <= '0;
      hit_ts  <= '0;
      hit_ovf <= 1'b0;
    end else begin
      if (cnt_run) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (hit_wr) begin
        for (int unsigned i = 0; i < MAX_HITS; i++) begin
          if (hit_cnt == HC_W'(i)) begin
            hit_ts[i*CNT_W +: CNT_W] <= cnt;
          end
        end
        hit_cnt <= hit_cnt + HC_W'(1);
      end
      if (ovf_set) begin
        hit_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Sequencer for one TDC ranging measurement in the LT_T1000 front end. On request it issues the `TDC_start` pulse that fires the laser/APD path, then opens a fixed coarse-time window. It synchronises the asynchronous APD `trig` returns and timestamps up to `MAX_HITS` of them with a coarse cycle counter. It presents the result record to the downstream fine-TDC/readout logic over a valid/ready handshake.

## Interface
- `CNT_W`, 16: coarse counter and timestamp width.
- `MAX_HITS`, 3: timestamp slots per measurement.
- `WINDOW`, 512: window length in clk cycles; 2048 ns at 250 MHz. Must satisfy 8 ≤ WINDOW < 2^CNT_W.
- `START_W`, 4: `tdc_start` high time in cycles.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `meas_req`, in, 1: single-cycle request; honoured only in IDLE.
- `trig`, in, 1: asynchronous APD return pulse, at least 2 clk cycles high.
- `tdc_start`, out, 1: start pulse to the APD/TDC path.
- `busy`, out, 1: high in every state except IDLE.
- `req_drop`, out, 1: one-cycle pulse when `meas_req` arrives outside IDLE.
- `res_valid`, out, 1: result record valid.
- `res_ready`, in, 1: downstream accepts the record.
- `hit_cnt`, out, 2: number of stored hits, 0..MAX_HITS.
- `hit_ts`, out, MAX_HITS*CNT_W: timestamps; slot i is at bits [i*CNT_W +: CNT_W].
- `hit_ovf`, out, 1: one or more edges were discarded because all slots were full.

## Operation
- States:
  - IDLE → START on `meas_req`.
  - START → WIN when `cnt == START_W-1`.
  - WIN → REPORT when `cnt == WINDOW-1`.
  - REPORT → IDLE on `res_valid & res_ready`.
- Entering START clears `cnt` to 0, `hit_cnt` to 0, all `hit_ts` slots to 0 and `hit_ovf` to 0.
- `cnt` increments by 1 every cycle in START and WIN. It holds its value in REPORT and IDLE.
- `tdc_start` is 1 exactly while in START, i.e. while `cnt` runs 0..START_W-1.
- `trig` passes through a 2-flop synchroniser (`trig_m`, `trig_s`) and then a delay flop `trig_q`. `edge = trig_s & ~trig_q`.
- An edge seen in START or WIN with `hit_cnt < MAX_HITS` does two things:
  - writes `cnt` into slot `hit_cnt`;
  - increments `hit_cnt` in the same cycle.
- An edge seen with `hit_cnt == MAX_HITS` sets `hit_ovf` and stores nothing.
- Edges seen in IDLE or REPORT are ignored and leave no state behind.
- An edge in the final WIN cycle (`cnt == WINDOW-1`) is captured.
- Result registers stay stable from REPORT entry until the next START, so they can still be read in IDLE.
- `req_drop` fires for `meas_req` in START, WIN or REPORT. That request is discarded and not queued.
- `meas_req` arriving in the same cycle the block returns to IDLE is dropped, since that cycle is still REPORT.

## Timing
- Reset values: state IDLE; `cnt`, `hit_cnt`, `hit_ts`, `hit_ovf` all 0; `tdc_start`, `busy`, `res_valid`, `req_drop` all 0; synchroniser flops 0.
- Reset mid-measurement: every output takes its reset value on the next edge. A pending result is lost.
- Request latency: `meas_req` sampled at edge k → `tdc_start` and `busy` high from edge k+1.
- Hit latency: 2 cycles. If `trig` is first sampled high at the end of the cycle with `cnt = N`, the stored timestamp is N+2.
- REPORT is entered WINDOW cycles after START entry.
- `res_valid` is high in REPORT only and is registered, so it rises 1 cycle after the final WIN cycle. It holds under backpressure indefinitely.
- Minimum request-to-request period: WINDOW+2 cycles with `res_ready` tied high.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package `tdc_ctrl_pkg` holds:
  - the state encoding (IDLE=0, START=1, WIN=2, REPORT=3);
  - default `CNT_W`, `MAX_HITS`, `WINDOW`, `START_W`;
  - the synchroniser latency constant `SYNC_LAT = 2`.
- Sub-module `trig_sync_edge`: 2-flop synchroniser plus rising-edge detect. It is reused later for the fine-TDC stop path.
- The FSM, counter and hit registers live in the top module.

## Test plan
- Single hit: `meas_req` → `trig` high from cnt=250 for 3 cycles → `hit_cnt`=1, slot0=252, `hit_ovf`=0, `res_valid` after 512 cycles.
- Three hits at cnt=250/255/261 → slots 252/257/263, `hit_cnt`=3.
- Four hits, with the fourth at cnt=400 → `hit_cnt`=3, `hit_ovf`=1, slots unchanged.
- No trig → `hit_cnt`=0, `res_valid`; hold `res_ready` low 20 cycles → record and valid stable; no new START until accepted.
- Edge cases:
  - trig at cnt=509 → slot0=511 (captured);
  - trig at cnt=510 → detected in REPORT, ignored.
- `meas_req` during WIN → `req_drop` pulse, no restart.
- `rst` during WIN → next cycle IDLE with all outputs 0.
- A fresh `meas_req` after reset works normally.
